stuffed_frame_tx: RTL and testbench

STUFFED_FRAME_TX -- requirements
Module: stuffed_frame_tx

---
 rtl/stuffed_frame_pkg.sv | 17 +
 rtl/stuffed_frame_tx.sv | 126 ++++++++++++
 tb/tb_stuffed_frame_tx.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/stuffed_frame_pkg.sv
// Shared definitions for the zero-stuffed serial frame transmitter.
// Holds the FSM state encoding and the flag/run-length constants.
package stuffed_frame_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLAG  = 3'd1,
    SEP   = 3'd2,
    DATA  = 3'd3,
    STUFF = 3'd4,
    TAIL  = 3'd5
  } state_t;

  localparam logic [1:0] FLAG_LEN  = 2'd3;
  localparam logic [1:0] RUN_LIMIT = 2'd2;

endpackage

// File: rtl/stuffed_frame_tx.sv
// Serial frame transmitter: flag 111, separator 0, MSB-first payload with a
// zero stuffed after every run of two ones, tail 0, then a one-cycle done pulse.
module stuffed_frame_tx
  import stuffed_frame_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              dout,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [1:0]        run_reg, run_next;
  logic [1:0]        flag_cnt_reg, flag_cnt_next;
  logic              dout_reg, dout_next;
  logic              done_reg, done_next;
  logic              emit;
  logic              msb;

  assign msb   = shift_reg[DATA_W-1];
  assign ready = (state_reg == IDLE);
  assign dout  = dout_reg;
  assign done  = done_reg;

  // dout_next is the bit belonging to state_next, so dout_reg always carries
  // the output of the state currently held in state_reg.
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    run_next      = run_reg;
    flag_cnt_next = flag_cnt_reg;
    dout_next     = 1'b0;
    done_next     = 1'b0;
    emit          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next    = FLAG;
          shift_next    = data;
          bit_cnt_next  = '0;
          run_next      = '0;
          flag_cnt_next = 2'd1;
          dout_next     = 1'b1;
        end
      end
      FLAG: begin
        if (flag_cnt_reg == FLAG_LEN) begin
          state_next = SEP;
          run_next   = '0;
        end else begin
          flag_cnt_next = flag_cnt_reg + 2'd1;
          dout_next     = 1'b1;
        end
      end
      SEP: begin
        emit = 1'b1;
      end
      DATA: begin
        if (run_reg == RUN_LIMIT) begin
          state_next = STUFF;
          run_next   = '0;
        end else if (bit_cnt_reg == LAST_CNT) begin
          state_next = TAIL;
        end else begin
          emit = 1'b1;
        end
      end
      STUFF: begin
        if (bit_cnt_reg == LAST_CNT) begin
          state_next = TAIL;
        end else begin
          emit = 1'b1;
        end
      end
      TAIL: begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Shared payload-bit emission used when entering DATA from SEP, DATA or STUFF.
    if (emit) begin
      state_next   = DATA;
      dout_next    = msb;
      shift_next   = {shift_reg[DATA_W-2:0], 1'b0};
      bit_cnt_next = bit_cnt_reg + 1'b1;
      run_next     = msb ? (run_reg + 2'd1) : 2'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      run_reg      <= '0;
      flag_cnt_reg <= '0;
      dout_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      run_reg      <= run_next;
      flag_cnt_reg <= flag_cnt_next;
      dout_reg     <= dout_next;
      done_reg     <= done_next;
    end
  end

endmodule

// File: tb/tb_stuffed_frame_tx.sv
// Self-checking bench for stuffed_frame_tx: expected frame bits are queued when
// a frame is requested and popped as the serial line produces them.
module tb_stuffed_frame_tx;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] data;
  logic       ready;
  logic       dout;
  logic       done;

  int checks   = 0;
  int failures = 0;
  bit exp_q[$];

  stuffed_frame_tx #(.DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .data  (data),
    .ready (ready),
    .dout  (dout),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: flag, separator, payload with a 0 after every two ones, tail.
  task automatic push_frame(input logic [7:0] d);
    int run;
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    run = 0;
    for (int i = 7; i >= 0; i--) begin
      exp_q.push_back(d[i]);
      run = d[i] ? run + 1 : 0;
      if (run == 2) begin
        exp_q.push_back(1'b0);
        run = 0;
      end
    end
    exp_q.push_back(1'b0);
  endtask

  // Called at a negedge with ready expected high; returns at the negedge of the done cycle.
  task automatic send_frame(input logic [7:0] d, input bit hold, input int exp_len);
    int n;
    int det;
    int pos;
    logic [2:0] win;
    bit e;
    chk("ready_before_start", ready, 1'b1);
    start = 1'b1;
    data  = d;
    push_frame(d);
    n   = exp_q.size();
    det = 0;
    pos = -1;
    win = 3'b000;
    @(posedge clk);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      start = hold;
      data  = 8'($urandom);
      e = exp_q.pop_front();
      chk($sformatf("dout_%02h_bit%0d", d, k), dout, e);
      chk("ready_busy", ready, 1'b0);
      chk("done_busy", done, 1'b0);
      win = {win[1:0], dout};
      if (win == 3'b111) begin
        det++;
        pos = k;
      end
    end
    @(negedge clk);
    chk("done_pulse", done, 1'b1);
    chk("ready_at_done", ready, 1'b1);
    chk("dout_at_done", dout, 1'b0);
    chk("det_count", det, 1);
    chk("det_pos", pos, 2);
    if (exp_len >= 0) chk("frame_len", n, exp_len);
    if (!hold) start = 1'b0;
    $display("frame data=%02h len=%0d hold=%0d checks=%0d failures=%0d", d, n, hold, checks, failures);
  endtask

  initial begin
    int gap;
    reset = 1'b1;
    start = 1'b0;
    data  = 8'h00;
    #2;
    chk("rst_dout", dout, 1'b0);
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_dout", dout, 1'b0);

    send_frame(8'h00, 1'b0, 13);
    @(negedge clk);
    chk("done_drop_00", done, 1'b0);
    send_frame(8'hFF, 1'b0, 17);
    @(negedge clk);
    chk("done_drop_ff", done, 1'b0);
    send_frame(8'hB6, 1'b0, 15);
    @(negedge clk);

    // start held high across frames while data keeps changing
    send_frame(8'h5A, 1'b1, -1);
    send_frame(8'hC3, 1'b1, -1);
    send_frame(8'h37, 1'b1, 15);
    start = 1'b0;
    @(negedge clk);
    chk("done_drop_b2b", done, 1'b0);
    chk("ready_after_b2b", ready, 1'b1);

    // abort a frame in the payload section
    start = 1'b1;
    data  = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_abort_busy", ready, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("abort_dout", dout, 1'b0);
    chk("abort_ready", ready, 1'b1);
    chk("abort_done", done, 1'b0);
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("abort_hold_done", done, 1'b0);
      chk("abort_hold_dout", dout, 1'b0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("post_abort_done", done, 1'b0);
    send_frame(8'h9F, 1'b0, -1);

    for (int f = 0; f < 100; f++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk("gap_done", done, 1'b0);
        chk("gap_dout", dout, 1'b0);
      end
      send_frame(8'($urandom), 1'b0, -1);
    end
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
